// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller: Tuse/Tnew
// encodings, the register-zero constant and default MDU latencies.
package hazard_stall_ctrl_pkg;

    typedef logic [1:0] timing_t;
    typedef logic [4:0] reg_idx_t;

    localparam timing_t  TUSE_NEVER = 2'd3;
    localparam timing_t  TNEW_NOW   = 2'd0;
    localparam reg_idx_t REG_ZERO   = 5'd0;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;
    localparam int MD_CNT_W            = 4;

    typedef enum logic {
        MD_OP_MULT = 1'b0,
        MD_OP_DIV  = 1'b1
    } md_op_e;

    // A source needed before its producer has the value cannot be forwarded.
    function automatic logic src_hazard(input reg_idx_t src, input timing_t tuse,
                                        input reg_idx_t dst, input timing_t tnew);
        return (src == dst) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy.sv
// MDU occupancy tracker: a start loads the operation latency, which then
// counts down to zero; busy covers the start cycle and every nonzero count.
module md_busy_counter
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic Clk,
    input  logic Reset,
    input  logic E_MDStart,
    input  logic E_MDIsDiv,
    output logic E_MD_Busy
);

    logic [MD_CNT_W-1:0] md_cnt_q;
    logic [MD_CNT_W-1:0] md_cnt_d;

    // A start while already counting reloads: the most recent start wins.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (E_MDStart) begin
            if (md_op_e'(E_MDIsDiv) == MD_OP_DIV) begin
                md_cnt_d = MD_CNT_W'(DIV_CYCLES);
            end else begin
                md_cnt_d = MD_CNT_W'(MULT_CYCLES);
            end
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign E_MD_Busy = E_MDStart | (md_cnt_q != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller: Tuse/Tnew data-hazard compare, optional MDU
// busy stall (built only when HAZARD_MDU_EN is defined) and stall-cycle counter.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES,
    parameter int CNT_W       = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       D_Rs,
    input  logic [4:0]       D_Rt,
    input  logic [1:0]       D_RsTuse,
    input  logic [1:0]       D_RtTuse,
    input  logic             D_IsMD,
    input  logic [4:0]       E_WriteReg,
    input  logic [1:0]       E_Tnew,
    input  logic [4:0]       M_WriteReg,
    input  logic [1:0]       M_Tnew,
    input  logic             E_MDStart,
    input  logic             E_MDIsDiv,
    output logic             F_PC_Enable,
    output logic             D_RegD_Enable,
    output logic             E_RegE_Clear,
    output logic             E_MD_Busy,
    output logic [CNT_W-1:0] StallCount
);

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    assign stall_rs = (D_Rs != REG_ZERO) &&
                      (src_hazard(D_Rs, D_RsTuse, E_WriteReg, E_Tnew) ||
                       src_hazard(D_Rs, D_RsTuse, M_WriteReg, M_Tnew));

    assign stall_rt = (D_Rt != REG_ZERO) &&
                      (src_hazard(D_Rt, D_RtTuse, E_WriteReg, E_Tnew) ||
                       src_hazard(D_Rt, D_RtTuse, M_WriteReg, M_Tnew));

`ifdef HAZARD_MDU_EN
    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy (
        .Clk       (Clk),
        .Reset     (Reset),
        .E_MDStart (E_MDStart),
        .E_MDIsDiv (E_MDIsDiv),
        .E_MD_Busy (E_MD_Busy)
    );

    assign stall_md = D_IsMD & E_MD_Busy;
`else
    // MDU inputs and latencies have no effect in this build.
    logic unused_md;
    assign unused_md = ^{E_MDStart, E_MDIsDiv, D_IsMD,
                         MD_CNT_W'(MULT_CYCLES), MD_CNT_W'(DIV_CYCLES)};

    assign E_MD_Busy = 1'b0;
    assign stall_md  = 1'b0;
`endif

    // Reset forces the pipeline to keep moving regardless of hazards.
    assign stall = (stall_rs | stall_rt | stall_md) & ~Reset;

    assign F_PC_Enable   = ~stall;
    assign D_RegD_Enable = ~stall;
    assign E_RegE_Clear  = stall;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; MDU checks follow HAZARD_MDU_EN.
module tb_hazard_stall_ctrl;

    logic        Clk;
    logic        Reset;
    logic [4:0]  D_Rs;
    logic [4:0]  D_Rt;
    logic [1:0]  D_RsTuse;
    logic [1:0]  D_RtTuse;
    logic        D_IsMD;
    logic [4:0]  E_WriteReg;
    logic [1:0]  E_Tnew;
    logic [4:0]  M_WriteReg;
    logic [1:0]  M_Tnew;
    logic        E_MDStart;
    logic        E_MDIsDiv;
    logic        F_PC_Enable;
    logic        D_RegD_Enable;
    logic        E_RegE_Clear;
    logic        E_MD_Busy;
    logic [31:0] StallCount;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_count;

    hazard_stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (32)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .D_Rs          (D_Rs),
        .D_Rt          (D_Rt),
        .D_RsTuse      (D_RsTuse),
        .D_RtTuse      (D_RtTuse),
        .D_IsMD        (D_IsMD),
        .E_WriteReg    (E_WriteReg),
        .E_Tnew        (E_Tnew),
        .M_WriteReg    (M_WriteReg),
        .M_Tnew        (M_Tnew),
        .E_MDStart     (E_MDStart),
        .E_MDIsDiv     (E_MDIsDiv),
        .F_PC_Enable   (F_PC_Enable),
        .D_RegD_Enable (D_RegD_Enable),
        .E_RegE_Clear  (E_RegE_Clear),
        .E_MD_Busy     (E_MD_Busy),
        .StallCount    (StallCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Inputs change at posedge+1; outputs are sampled at posedge+3.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_stall(input string tag, input logic s);
        check({tag, ".pc_en"}, {31'd0, F_PC_Enable}, {31'd0, ~s});
        check({tag, ".regd_en"}, {31'd0, D_RegD_Enable}, {31'd0, ~s});
        check({tag, ".rege_clr"}, {31'd0, E_RegE_Clear}, {31'd0, s});
    endtask

    task automatic set_idle();
        D_Rs = 5'd0; D_Rt = 5'd0; D_RsTuse = 2'd3; D_RtTuse = 2'd3; D_IsMD = 1'b0;
        E_WriteReg = 5'd0; E_Tnew = 2'd0; M_WriteReg = 5'd0; M_Tnew = 2'd0;
        E_MDStart = 1'b0; E_MDIsDiv = 1'b0;
    endtask

    typedef struct {
        logic [4:0] rs, rt;
        logic [1:0] rs_tuse, rt_tuse;
        logic [4:0] e_wr;
        logic [1:0] e_tnew;
        logic [4:0] m_wr;
        logic [1:0] m_tnew;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[10];

    initial begin
        //          rs     rt     rsTu   rtTu   E_wr   E_tn   M_wr   M_tn   stall
        vecs[0] = '{5'd5,  5'd0,  2'd0,  2'd3,  5'd5,  2'd2,  5'd0,  2'd0,  1'b1}; // load-use
        vecs[1] = '{5'd0,  5'd5,  2'd3,  2'd1,  5'd0,  2'd0,  5'd5,  2'd1,  1'b0}; // forwardable
        vecs[2] = '{5'd0,  5'd0,  2'd0,  2'd3,  5'd0,  2'd2,  5'd0,  2'd0,  1'b0}; // reg zero
        vecs[3] = '{5'd7,  5'd0,  2'd1,  2'd3,  5'd7,  2'd2,  5'd0,  2'd0,  1'b1};
        vecs[4] = '{5'd7,  5'd0,  2'd3,  2'd3,  5'd7,  2'd2,  5'd0,  2'd0,  1'b0}; // never used
        vecs[5] = '{5'd0,  5'd9,  2'd3,  2'd0,  5'd0,  2'd0,  5'd9,  2'd1,  1'b1}; // rt vs M
        vecs[6] = '{5'd4,  5'd0,  2'd1,  2'd3,  5'd4,  2'd1,  5'd4,  2'd2,  1'b1}; // M side holds
        vecs[7] = '{5'd4,  5'd0,  2'd1,  2'd3,  5'd4,  2'd1,  5'd4,  2'd1,  1'b0};
        vecs[8] = '{5'd3,  5'd3,  2'd0,  2'd3,  5'd2,  2'd2,  5'd3,  2'd0,  1'b0};
        vecs[9] = '{5'd0,  5'd31, 2'd3,  2'd0,  5'd31, 2'd1,  5'd0,  2'd0,  1'b1};
    end

    initial begin
        set_idle();
        Reset = 1'b1;
        exp_count = 32'd0;
        // Reset with a live load-use hazard: enables must stay asserted.
        #1;
        D_Rs = 5'd5; D_RsTuse = 2'd0; E_WriteReg = 5'd5; E_Tnew = 2'd2;
        step();
        settle();
        check_stall("reset_hazard", 1'b0);
        check("reset_busy", {31'd0, E_MD_Busy}, 32'd0);
        step();
        check("reset_count", StallCount, 32'd0);
        Reset = 1'b0;
        set_idle();
        settle();
        check_stall("idle", 1'b0);

        for (int i = 0; i < 10; i++) begin
            D_Rs = vecs[i].rs; D_Rt = vecs[i].rt;
            D_RsTuse = vecs[i].rs_tuse; D_RtTuse = vecs[i].rt_tuse;
            E_WriteReg = vecs[i].e_wr; E_Tnew = vecs[i].e_tnew;
            M_WriteReg = vecs[i].m_wr; M_Tnew = vecs[i].m_tnew;
            settle();
            check_stall($sformatf("vec%0d", i), vecs[i].exp_stall);
            step();
            if (vecs[i].exp_stall) exp_count = exp_count + 32'd1;
            set_idle();
            settle();
            check($sformatf("vec%0d.count", i), StallCount, exp_count);
        end
        check("data_total", exp_count, 32'd5);

`ifdef HAZARD_MDU_EN
        // Div with MD instruction held in D: busy and stall in cycles 0..10.
        E_MDStart = 1'b1; E_MDIsDiv = 1'b1; D_IsMD = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            settle();
            check($sformatf("div_busy_c%0d", c), {31'd0, E_MD_Busy}, {31'd0, c <= 10});
            check_stall($sformatf("div_c%0d", c), c <= 10);
            step();
            E_MDStart = 1'b0;
        end
        exp_count = exp_count + 32'd11;
        D_IsMD = 1'b0;
        settle();
        check("div_count", StallCount, exp_count);

        // Mult with no MD instruction in D: busy t..t+5, no stall.
        E_MDStart = 1'b1; E_MDIsDiv = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            settle();
            check($sformatf("mult_busy_c%0d", c), {31'd0, E_MD_Busy}, {31'd0, c <= 5});
            check_stall($sformatf("mult_c%0d", c), 1'b0);
            step();
            E_MDStart = 1'b0;
        end
        settle();
        check("mult_count", StallCount, exp_count);

        // Reset in cycle 3 of a div countdown aborts it.
        E_MDStart = 1'b1; E_MDIsDiv = 1'b1; D_IsMD = 1'b1;
        step();
        E_MDStart = 1'b0;
        step();
        step();
        Reset = 1'b1;
        settle();
        check_stall("md_reset", 1'b0);
        step();
        Reset = 1'b0;
        exp_count = 32'd0;
        settle();
        check("md_reset_busy", {31'd0, E_MD_Busy}, 32'd0);
        check_stall("md_reset_after", 1'b0);
        check("md_reset_count", StallCount, exp_count);
        D_IsMD = 1'b0;
`else
        // MDU disabled: starts and MD instructions never cause busy or stall.
        E_MDStart = 1'b1; E_MDIsDiv = 1'b1; D_IsMD = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("nomdu_busy_c%0d", c), {31'd0, E_MD_Busy}, 32'd0);
            check_stall($sformatf("nomdu_c%0d", c), 1'b0);
            step();
        end
        settle();
        check("nomdu_count", StallCount, exp_count);
        set_idle();
        // Reset clears accumulated stall count.
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        exp_count = 32'd0;
        settle();
        check("late_reset_count", StallCount, exp_count);
`endif

        // A 3-cycle stall after reset adds exactly 3.
        D_Rt = 5'd12; D_RtTuse = 2'd0; M_WriteReg = 5'd12; M_Tnew = 2'd2;
        for (int c = 0; c < 3; c++) begin
            settle();
            check_stall($sformatf("run_c%0d", c), 1'b1);
            step();
            exp_count = exp_count + 32'd1;
            settle();
            check($sformatf("run_count_c%0d", c), StallCount, exp_count);
        end
        set_idle();
        settle();
        check_stall("run_end", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Central stall/flush controller for the five-stage pipeline. It compares the register sources of the instruction in D against the pending destinations in E and M using Tuse/Tnew timing. It also tracks multiply/divide-unit occupancy with an internal busy countdown. From these it drives the F-stage PC enable, the F→D pipeline-register enable and the D→E bubble insert, and it keeps a running count of stall cycles for performance reporting.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start
- DIV_CYCLES, 10, busy cycles after a div/divu start
- CNT_W, 32, width of stall-cycle counter

Ports (reset Reset, synchronous, active-high; clock Clk):
- Clk  in  1  clock, posedge
- Reset  in  1  synchronous active-high reset
- D_Rs  in  5  rs field of D instruction
- D_Rt  in  5  rt field of D instruction
- D_RsTuse  in  2  cycles until rs is consumed (3 = never used)
- D_RtTuse  in  2  cycles until rt is consumed (3 = never used)
- D_IsMD  in  1  D instruction uses MDU (mult/div/mfhi/mflo/mthi/mtlo)
- E_WriteReg  in  5  destination of E instruction (0 = none)
- E_Tnew  in  2  cycles until E result is available
- M_WriteReg  in  5  destination of M instruction (0 = none)
- M_Tnew  in  2  cycles until M result is available
- E_MDStart  in  1  E instruction starts a mult/div this cycle
- E_MDIsDiv  in  1  qualifies E_MDStart: 1 = div/divu, 0 = mult/multu
- F_PC_Enable  out  1  PC update enable
- D_RegD_Enable  out  1  F→D register load enable
- E_RegE_Clear  out  1  load a nop bubble into E
- E_MD_Busy  out  1  MDU occupied
- StallCount  out  CNT_W  total stall cycles since reset

## Operation
- Data stall:
  - stall_rs = (D_Rs≠0) & ((D_Rs==E_WriteReg & D_RsTuse<E_Tnew) | (D_Rs==M_WriteReg & D_RsTuse<M_Tnew)).
  - stall_rt is defined the same way using D_Rt and D_RtTuse.
- MDU busy counter:
  - MD_Cnt is a 4-bit down-counter.
  - E_MDStart loads MULT_CYCLES or DIV_CYCLES, selected by E_MDIsDiv.
  - Otherwise, if MD_Cnt≠0, it decrements by 1 each cycle.
  - E_MD_Busy = E_MDStart | (MD_Cnt≠0).
- stall_md = D_IsMD & E_MD_Busy.
- stall = (stall_rs | stall_rt | stall_md) & ~Reset.
- Outputs are combinational: F_PC_Enable = D_RegD_Enable = ~stall; E_RegE_Clear = stall.
- StallCount increments by 1 on every cycle where stall=1, and wraps modulo 2^CNT_W.
- Boundaries:
  - Register 0 never causes a stall.
  - E_MDStart while MD_Cnt≠0 cannot legally occur, because stall_md holds MD instructions in D. If it does occur, the counter reloads (last start wins).
  - A match in both E and M stalls if either condition holds.
  - Tuse=3 never stalls, since Tnew ≤ 2.

## Timing
- Reset (synchronous) clears MD_Cnt and StallCount to 0.
- While Reset is high: F_PC_Enable=1, D_RegD_Enable=1, E_RegE_Clear=0, E_MD_Busy=0, StallCount=0 on the following edge.
- Stall outputs have zero latency, in the same cycle as their inputs. Upstream stages apply them at the next posedge.
- After E_MDStart in cycle t, E_MD_Busy is high in cycles t through t+N, where N = MULT_CYCLES or DIV_CYCLES.
- An MD instruction in D advances in cycle t+N+1.
- Reset asserted mid-busy aborts the countdown: E_MD_Busy=0 on the next cycle.
- A stall lasting k cycles adds exactly k to StallCount. The counter value is visible one cycle after each stall cycle.

## Configuration
- HAZARD_MDU_EN defined: the MDU busy counter and stall_md are built as described.
- HAZARD_MDU_EN undefined:
  - MD_Cnt is omitted; E_MD_Busy is tied 0 and stall_md is 0.
  - E_MDStart, E_MDIsDiv and D_IsMD are ignored.
  - MULT_CYCLES and DIV_CYCLES are unused.

## Structure
- The shared pipeline package holds:
  - Tuse/Tnew encodings (TUSE_NEVER=2'd3);
  - the register-zero constant;
  - default MULT_CYCLES and DIV_CYCLES values.
- One sub-module, md_busy_counter, holds the load/decrement counter and busy output. It is instantiated only under HAZARD_MDU_EN.
- The data-hazard compare and StallCount stay in the top module.

## Test plan
- Load-use: D_Rs=5, D_RsTuse=0; E_WriteReg=5, E_Tnew=2 → stall: F_PC_Enable=0, D_RegD_Enable=0, E_RegE_Clear=1, and StallCount +1.
- Forwardable: D_Rt=5, D_RtTuse=1; M_WriteReg=5, M_Tnew=1 → no stall. Register-zero case: D_Rs=0, E_WriteReg=0, E_Tnew=2 → no stall.
- Div busy: E_MDStart=1, E_MDIsDiv=1 at cycle 0, with D_IsMD=1 held → E_MD_Busy=1 and stall through cycle 10, release at cycle 11, StallCount=11.
- Mult: E_MDStart=1, E_MDIsDiv=0 → E_MD_Busy high for 6 cycles (t..t+5). With D_IsMD=0 no stall occurs, and StallCount is unchanged.
- Reset at cycle 3 of a div countdown → next cycle E_MD_Busy=0 and StallCount=0. During Reset, enables=1 even with a matching hazard.
- Build without HAZARD_MDU_EN: E_MDStart=1, D_IsMD=1 → E_MD_Busy=0, no stall.
